pixel_frame_ctrl: RTL and testbench

Frame sequencer for the per-pixel RGB filter datapath. On start it walks a frame buffer in row-major order, issues one read per pixel, passes each pixel through the selected point operation (bypass / negation / grayscale), and streams results out over a valid/ready handshake with frame and line markers. It sits between the frame-buffer read port and the output writer, which dumps the processed image as hex.

---
 rtl/pixel_pkg.sv | 32 +++
 rtl/pixel_point_op.sv | 23 ++
 rtl/pixel_frame_ctrl.sv | 145 ++++++++++++++
 tb/tb_pixel_frame_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared types for the pixel frame sequencer: point-op mode codes, RGB packing,
// buffered pixel record and sequencer state encoding.
package pixel_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_NEGATE = 2'd1;
  localparam logic [1:0] MODE_GRAY   = 2'd2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    rgb_t data;
    logic sof;
    logic eol;
    logic eof;
  } pix_t;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  function automatic rgb_t rgb_negate(rgb_t p);
    rgb_t n;
    n.r = 8'd255 - p.r;
    n.g = 8'd255 - p.g;
    n.b = 8'd255 - p.b;
    return n;
  endfunction

endpackage

// File: rtl/pixel_point_op.sv
// Combinational per-pixel point operation: bypass, negation or grayscale.
module pixel_point_op
  import pixel_pkg::*;
(
  input  rgb_t       pix_in,
  input  logic [1:0] mode,
  output rgb_t       pix_out
);

  logic [9:0] luma_sum;
  logic [7:0] luma;

  always_comb begin
    luma_sum = {2'b00, pix_in.r} + {1'b0, pix_in.g, 1'b0} + {2'b00, pix_in.b};
    luma     = luma_sum[9:2];
    case (mode)
      MODE_NEGATE: pix_out = rgb_negate(pix_in);
      MODE_GRAY:   pix_out = '{r: luma, g: luma, b: luma};
      default:     pix_out = pix_in;
    endcase
  end

endmodule

// File: rtl/pixel_frame_ctrl.sv
// Frame sequencer: walks the frame buffer row-major, applies the point op and
// streams pixels out through a 2-entry buffer with sof/eol/eof markers.
module pixel_frame_ctrl
  import pixel_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DIM_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  input  logic [1:0]        mode,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [23:0]       rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [23:0]       out_data,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy,
  output logic              done
);

  state_e             state_q, state_d;
  logic [DIM_W-1:0]   w_q, h_q, x_q, y_q;
  logic [1:0]         mode_q;
  logic [ADDR_W-1:0]  addr_q, total_q;
  logic               zero_q, inflight_q, done_q;
  logic [2:0]         tag_q;  // {sof, eol, eof} of the read in flight
  pix_t               buf_q [2];
  logic               rd_ptr_q, wr_ptr_q;
  logic [1:0]         count_q, count_d;

  logic [2*DIM_W-1:0] frame_px;
  logic               room, issue, last_rd, eol_now, valid, pop, push;
  rgb_t               rd_pix, op_out;
  pix_t               in_pix, head;

  assign rd_pix = rd_data;

  pixel_point_op u_point_op (
    .pix_in  (rd_pix),
    .mode    (mode_q),
    .pix_out (op_out)
  );

  always_comb begin
    frame_px = img_w * img_h;
    // Buffered entries plus the read in flight must leave a free slot.
    room     = ({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2;
    issue    = (state_q == StRun) && room;
    last_rd  = issue && (addr_q == total_q - 1'b1);
    eol_now  = (x_q == w_q - 1'b1);
    in_pix   = '{data: op_out, sof: tag_q[2], eol: tag_q[1], eof: tag_q[0]};
    // Empty buffer: the returning read is presented directly.
    head     = (count_q != 2'd0) ? buf_q[rd_ptr_q] : in_pix;
    valid    = (count_q != 2'd0) || inflight_q;
    pop      = valid && out_ready;
    push     = inflight_q && !((count_q == 2'd0) && pop);
    count_d  = count_q + {1'b0, inflight_q} - {1'b0, pop};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = ((img_w == '0) || (img_h == '0)) ? StDone : StRun;
      StRun:   if (last_rd) state_d = StDrain;
      StDrain: if (count_d == 2'd0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      w_q        <= '0;
      h_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      mode_q     <= MODE_BYPASS;
      addr_q     <= '0;
      total_q    <= '0;
      zero_q     <= 1'b0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      done_q     <= (pop && head.eof) || ((state_q == StDone) && zero_q);
      if ((state_q == StIdle) && start) begin
        w_q     <= img_w;
        h_q     <= img_h;
        mode_q  <= mode;
        total_q <= ADDR_W'(frame_px);
        zero_q  <= (img_w == '0) || (img_h == '0);
        addr_q  <= '0;
        x_q     <= '0;
        y_q     <= '0;
      end else if (issue) begin
        addr_q <= addr_q + 1'b1;
        tag_q  <= {(x_q == '0) && (y_q == '0), eol_now, eol_now && (y_q == h_q - 1'b1)};
        if (eol_now) begin
          x_q <= '0;
          y_q <= y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        buf_q[wr_ptr_q] <= in_pix;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop && (count_q != 2'd0)) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign rd_en     = issue;
  assign rd_addr   = addr_q;
  assign out_valid = valid;
  assign out_data  = valid ? head.data : '0;
  assign out_sof   = valid && head.sof;
  assign out_eol   = valid && head.eol;
  assign out_eof   = valid && head.eof;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// Randomised bench for pixel_frame_ctrl with a queue-based frame model and a
// per-cycle compare process.
module tb_pixel_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  img_w = '0;
  logic [7:0]  img_h = '0;
  logic [1:0]  mode = '0;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [23:0] rd_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_data;
  logic        out_sof, out_eol, out_eof, busy, done;

  always #5 clk = ~clk;

  pixel_frame_ctrl #(.ADDR_W(16), .DIM_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .img_w     (img_w),
    .img_h     (img_h),
    .mode      (mode),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .out_eof   (out_eof),
    .busy      (busy),
    .done      (done)
  );

  // Frame buffer: data one cycle after rd_en, garbage otherwise.
  logic [23:0] fb [0:1023];
  always @(posedge clk) rd_data <= rd_en ? fb[rd_addr[9:0]] : 24'($urandom);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  int rmode = 0;
  int rd_cnt = 0, total_exp = 0, npops = 0, done_due = -1;
  logic [26:0] exp_q[$];
  logic [26:0] acc_q[$];
  bit prev_eof_hs = 0, prev_stall = 0;
  logic [26:0] prev_out = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [23:0] model_op(input logic [1:0] m, input logic [23:0] p);
    int r, g, b, y;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    if (m == 2'd1) return {8'(255 - r), 8'(255 - g), 8'(255 - b)};
    if (m == 2'd2) begin
      y = (r + 2 * g + b) / 4;
      return {8'(y), 8'(y), 8'(y)};
    end
    return p;
  endfunction

  task automatic build_frame(input int w, input int h, input logic [1:0] m);
    int x, y;
    exp_q.delete();
    for (int i = 0; i < w * h; i++) begin
      x = i % w;
      y = i / w;
      exp_q.push_back({model_op(m, fb[i]), (x == 0 && y == 0), (x == w - 1),
                       (x == w - 1 && y == h - 1)});
    end
    total_exp = w * h;
    rd_cnt = 0;
    npops = 0;
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (rmode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ctrl", {rd_en, out_valid, out_sof, out_eol, out_eof, busy, done}, 0);
      chk("rst_data", {rd_addr, out_data}, 0);
      exp_q.delete();
      rd_cnt = 0;
      total_exp = 0;
      npops = 0;
      prev_eof_hs = 0;
      prev_stall = 0;
    end else begin
      chk("done", done, prev_eof_hs || (cyc == done_due));
      prev_eof_hs = 0;
      if (rd_en) begin
        chk("rd_addr", rd_addr, 16'(rd_cnt));
        chk("rd_extra", rd_cnt < total_exp, 1);
        rd_cnt++;
      end
      if (prev_stall)
        chk("hold", {out_valid, out_data, out_sof, out_eol, out_eof}, {1'b1, prev_out});
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_valid", out_valid, 0);
        else chk("pixel", {out_data, out_sof, out_eol, out_eof}, exp_q[0]);
        if (out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          acc_q.push_back({out_data, out_sof, out_eol, out_eof});
          prev_eof_hs = out_eof;
          npops++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out = {out_data, out_sof, out_eol, out_eof};
      chk("occupancy", (rd_cnt - npops) <= 2, 1);
    end
  end

  task automatic start_frame(input int w, input int h, input logic [1:0] m, input int rm);
    int c;
    @(posedge clk);
    #1;
    done_due = -1;
    build_frame(w, h, m);
    rmode = rm;
    acc_q.delete();
    img_w = 8'(w);
    img_h = 8'(h);
    mode = m;
    start = 1'b1;
    c = cyc;
    if (w == 0 || h == 0) done_due = c + 2;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_start", busy, 1);
  endtask

  task automatic finish_frame(input bit mid_start, input logic [1:0] m);
    bit got;
    got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(posedge clk);
      #1;
      if (mid_start && i == 3) begin
        start = 1'b1;
        mode = ~m;
        img_w = 8'd3;
        img_h = 8'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) got = 1;
    end
    chk("done_seen", got, 1);
    chk("frame_left", exp_q.size(), 0);
    chk("read_count", rd_cnt, total_exp);
    @(posedge clk);
    #1;
    chk("busy_idle", busy, 0);
  endtask

  task automatic run_frame(input int w, input int h, input logic [1:0] m, input int rm);
    start_frame(w, h, m, rm);
    finish_frame(1'b0, m);
  endtask

  logic [7:0] sofv, eolv, eofv;

  initial begin
    for (int i = 0; i < 1024; i++) fb[i] = {8'(i), 8'(i), 8'(i)};
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 4x2 negate, always ready; pin the model with literal results.
    run_frame(4, 2, 2'd1, 0);
    chk("t1_count", acc_q.size(), 8);
    if (acc_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        sofv[i] = acc_q[i][2];
        eolv[i] = acc_q[i][1];
        eofv[i] = acc_q[i][0];
      end
      chk("t1_first", acc_q[0][26:3], 24'hFFFFFF);
      chk("t1_last", acc_q[7][26:3], 24'hF8F8F8);
      chk("t1_sof", sofv, 8'h01);
      chk("t1_eol", eolv, 8'h88);
      chk("t1_eof", eofv, 8'h80);
    end

    run_frame(4, 2, 2'd1, 1);
    chk("t2_toggle_count", acc_q.size(), 8);
    run_frame(4, 2, 2'd1, 2);
    chk("t2_random_count", acc_q.size(), 8);

    fb[0] = 24'h0A141E;
    fb[1] = 24'hFFFFFF;
    run_frame(2, 1, 2'd2, 2);
    chk("gray_count", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      chk("gray_0", acc_q[0][26:3], 24'h141414);
      chk("gray_1", acc_q[1][26:3], 24'hFFFFFF);
    end

    run_frame(0, 5, 2'd0, 0);
    chk("zero_out", acc_q.size(), 0);

    fb[0] = 24'h123456;
    run_frame(1, 1, 2'd3, 0);
    chk("one_px", acc_q.size() == 1 ? acc_q[0] : 27'h0, {24'h123456, 3'b111});

    for (int i = 0; i < 1024; i++) fb[i] = {8'(i), 8'(i), 8'(i)};
    start_frame(4, 2, 2'd1, 1);
    finish_frame(1'b1, 2'd1);
    chk("midstart_count", acc_q.size(), 8);

    // Reset in the middle of a frame.
    start_frame(4, 2, 2'd1, 0);
    for (int i = 0; i < 200 && acc_q.size() < 3; i++) @(negedge clk);
    chk("rst_reach", acc_q.size() >= 3, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_idle", {rd_en, out_valid, busy}, 0);
    end
    run_frame(4, 2, 2'd1, 0);
    chk("rst_restart", acc_q.size() != 0 ? acc_q[0] : 27'h0, {24'hFFFFFF, 3'b100});

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 64; i++) fb[i] = 24'($urandom);
      run_frame(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)),
                2'($urandom_range(0, 3)), 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
